// File: rtl/i2s_mic_rx.sv
// I2S master receiver for a stereo pair of 24-bit MEMS microphones.
// Generates SCK/WS from clk_i, deserialises SD and presents a coherent
// left/right pair with a one-cycle strobe once per 64-bit frame.
module i2s_mic_rx #(
    parameter int unsigned SCK_DIV = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        sd_i,
    output logic        sck_o,
    output logic        ws_o,
    output logic [23:0] left_sample_o,
    output logic [23:0] right_sample_o,
    output logic        sample_stb_o
);

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned BIT_W    = 6;
    localparam int unsigned DIV_W    = $clog2(SCK_DIV);

    localparam logic [BIT_W-1:0] SLOT_IDLE      = 6'd63;
    localparam logic [BIT_W-1:0] SLOT_LEFT_LSB  = 6'd23;
    localparam logic [BIT_W-1:0] SLOT_RIGHT_LSB = 6'd55;
    localparam logic [BIT_W-1:0] SLOT_WS_FIRST  = 6'd31;
    localparam logic [BIT_W-1:0] SLOT_WS_LAST   = 6'd62;
    localparam logic [DIV_W-1:0] DIV_LAST       = DIV_W'(SCK_DIV - 1);

    logic [DIV_W-1:0]    div_q, div_d;
    logic                sck_q, sck_d;
    logic                ws_q, ws_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic [SAMPLE_W-1:0] left_q, left_d;
    logic [SAMPLE_W-1:0] right_q, right_d;
    logic                stb_q, stb_d;
    logic                sd_meta_q, sd_sync_q;

    logic                div_end_c;
    logic                fall_c;
    logic                in_word_c;
    logic [SAMPLE_W-1:0] shift_in_c;

    assign div_end_c  = (div_q == DIV_LAST);
    // The clk cycle whose edge drives sck 1->0 is the fall event.
    assign fall_c     = en_i && div_end_c && sck_q;
    // Slots 0..23 and 32..55 carry data; the remaining 8 of each half are filler.
    assign in_word_c  = (bit_q[4:0] < 5'd24);
    assign shift_in_c = {shift_q[SAMPLE_W-2:0], sd_sync_q};

    // Two-flop synchroniser for the asynchronous microphone data line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sd_meta_q <= 1'b0;
            sd_sync_q <= 1'b0;
        end else begin
            sd_meta_q <= sd_i;
            sd_sync_q <= sd_meta_q;
        end
    end

    // Next-state: SCK divider, bit/slot counter, WS, deserialiser and capture.
    always_comb begin
        div_d   = div_q;
        sck_d   = sck_q;
        ws_d    = ws_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        left_d  = left_q;
        right_d = right_q;
        stb_d   = 1'b0;

        if (!en_i) begin
            div_d = '0;
            sck_d = 1'b0;
            ws_d  = 1'b0;
            bit_d = SLOT_IDLE;
        end else begin
            if (div_end_c) begin
                div_d = '0;
                sck_d = ~sck_q;
            end else begin
                div_d = div_q + DIV_W'(1);
            end

            if (fall_c) begin
                bit_d = bit_q + BIT_W'(1);
                // WS leads each word by one slot.
                ws_d  = (bit_d >= SLOT_WS_FIRST) && (bit_d <= SLOT_WS_LAST);
                if (in_word_c) begin
                    shift_d = shift_in_c;
                end
                if (bit_q == SLOT_LEFT_LSB) begin
                    hold_d = shift_in_c;
                end
                if (bit_q == SLOT_RIGHT_LSB) begin
                    left_d  = hold_q;
                    right_d = shift_in_c;
                    stb_d   = 1'b1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= '0;
            sck_q   <= 1'b0;
            ws_q    <= 1'b0;
            bit_q   <= SLOT_IDLE;
            shift_q <= '0;
            hold_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            stb_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            sck_q   <= sck_d;
            ws_q    <= ws_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            left_q  <= left_d;
            right_q <= right_d;
            stb_q   <= stb_d;
        end
    end

    assign sck_o          = sck_q;
    assign ws_o           = ws_q;
    assign left_sample_o  = left_q;
    assign right_sample_o = right_q;
    assign sample_stb_o   = stb_q;

endmodule
